// File: rtl/srisc_pkg.sv
// Shared definitions for the SimpleRisc writeback path: register file
// geometry, the writeback request bundle, the writeback arbiter states and
// a small saturating-counter helper.
package srisc_pkg;

    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 4;

    // Return-address register; only the register file's read side treats it specially.
    localparam logic [AW-1:0] RA_REG = 4'd15;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_NORMAL = 1'b0,
        WB_STEAL  = 1'b1
    } wb_state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Busy scoreboard for long-latency destinations. A register is marked busy
// when a mul/div instruction issues and released when its result is written.
// The hazard output looks only at the registered busy bits, so a register
// being released this cycle still stalls decode for one more cycle.
module reg_scoreboard #(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          chk_valid,
    input  logic          set_req,
    input  logic [AW-1:0] chk_rd,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_adr,
    output logic          hazard
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            set_en;

    // Stall whenever any operand or the destination is still owed a mul/div result.
    always_comb begin
        hazard = chk_valid & (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]);
    end

    // A stalled instruction is not really issued, so it must not claim its destination.
    always_comb begin
        set_en = chk_valid & set_req & ~hazard;
    end

    // Apply the release first so that a new claim on the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_adr] = 1'b0;
        end
        if (set_en) begin
            busy_next[chk_rd] = 1'b1;
        end
    end

    // Busy vector storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Sole driver of the register file write port. The ALU/load stream has
// priority because it cannot be stalled; the mul/div unit takes any slot the
// ALU leaves free. If mul/div is refused STARVE_LIMIT cycles in a row, the
// next cycle is reserved for it by raising wb_hold towards the pipeline.
module regfile_wb_scheduler #(
    parameter int NREG         = srisc_pkg::NREG,
    parameter int AW           = srisc_pkg::AW,
    parameter int DW           = srisc_pkg::DW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_wb_valid,
    input  logic [AW-1:0] alu_wb_adr,
    input  logic [DW-1:0] alu_wb_data,
    input  logic          md_valid,
    input  logic [AW-1:0] md_adr,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic          iss_valid,
    input  logic          iss_long,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    output logic          hazard,
    output logic          wb_hold,
    output logic          is_wb,
    output logic [AW-1:0] wr_adr,
    output logic [DW-1:0] wr_data
);

    import srisc_pkg::*;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    wb_state_t        state;
    wb_state_t        state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;

    logic    alu_win;
    logic    md_fire;
    logic    md_denied;
    wb_req_t alu_req;
    wb_req_t md_req;
    wb_req_t win_req;

    // The request structs share the package widths, which match the defaults here.
    always_comb begin
        alu_req.valid = alu_wb_valid;
        alu_req.adr   = alu_wb_adr;
        alu_req.data  = alu_wb_data;
        md_req.valid  = md_valid;
        md_req.adr    = md_adr;
        md_req.data   = md_data;
    end

    // Arbitration: during a held slot an illegal ALU write is dropped and mul/div goes.
    always_comb begin
        alu_win   = alu_req.valid & ~wb_hold;
        md_ready  = md_req.valid & ~alu_win;
        md_fire   = md_req.valid & md_ready;
        md_denied = md_req.valid & ~md_ready;
        win_req   = alu_win ? alu_req : md_req;
        win_req.valid = alu_win | md_fire;
    end

    // Starvation guard: count consecutive refusals and steal a single slot at the limit.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            WB_NORMAL: begin
                if (md_denied) begin
                    starve_next = sat_inc(starve_cnt, LIMIT);
                    if (starve_cnt >= LIMIT_M1) begin
                        state_next = WB_STEAL;
                    end
                end else begin
                    starve_next = '0;
                end
            end
            WB_STEAL: begin
                state_next  = WB_NORMAL;
                starve_next = '0;
            end
            default: begin
                state_next  = WB_NORMAL;
                starve_next = '0;
            end
        endcase
    end

    // FSM and refusal counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WB_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // The hold flag is the registered STEAL state itself.
    always_comb begin
        wb_hold = (state == WB_STEAL);
    end

    // Register file write port; address and data keep their last value when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_wb   <= 1'b0;
            wr_adr  <= '0;
            wr_data <= '0;
        end else begin
            is_wb <= win_req.valid;
            if (win_req.valid) begin
                wr_adr  <= win_req.adr;
                wr_data <= win_req.data;
            end
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .chk_valid (iss_valid),
        .set_req   (iss_long),
        .chk_rd    (iss_rd),
        .chk_rs1   (iss_rs1),
        .chk_rs2   (iss_rs2),
        .clr_en    (md_fire),
        .clr_adr   (md_adr),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios followed
// by random traffic, all compared against a cycle-level reference model.
module tb_regfile_wb_scheduler;

    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_adr;
    logic [31:0] alu_wb_data;
    logic        md_valid;
    logic [3:0]  md_adr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        iss_valid;
    logic        iss_long;
    logic [3:0]  iss_rd;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic        hazard;
    logic        wb_hold;
    logic        is_wb;
    logic [3:0]  wr_adr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_busy [16];
    int          m_run;
    bit          m_hold;
    bit          m_is_wb;
    logic [3:0]  m_adr;
    logic [31:0] m_data;

    regfile_wb_scheduler #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_adr   (alu_wb_adr),
        .alu_wb_data  (alu_wb_data),
        .md_valid     (md_valid),
        .md_adr       (md_adr),
        .md_data      (md_data),
        .md_ready     (md_ready),
        .iss_valid    (iss_valid),
        .iss_long     (iss_long),
        .iss_rd       (iss_rd),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .hazard       (hazard),
        .wb_hold      (wb_hold),
        .is_wb        (is_wb),
        .wr_adr       (wr_adr),
        .wr_data      (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_run   = 0;
        m_hold  = 1'b0;
        m_is_wb = 1'b0;
        m_adr   = '0;
        m_data  = '0;
    endtask

    function automatic bit exp_md_ready();
        return md_valid && !(alu_wb_valid && !m_hold);
    endfunction

    function automatic bit exp_hazard();
        return iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        bit alu_takes;
        bit md_takes;
        bit haz;
        alu_takes = alu_wb_valid && !m_hold;
        md_takes  = md_valid && !alu_takes;
        haz       = exp_hazard();
        if (alu_takes) begin
            m_is_wb = 1'b1; m_adr = alu_wb_adr; m_data = alu_wb_data;
        end else if (md_takes) begin
            m_is_wb = 1'b1; m_adr = md_adr; m_data = md_data;
        end else begin
            m_is_wb = 1'b0;
        end
        if (m_hold) begin
            m_hold = 1'b0;
            m_run  = 0;
        end else if (md_valid && !md_takes) begin
            m_run++;
            if (m_run == STARVE_LIMIT) m_hold = 1'b1;
        end else begin
            m_run = 0;
        end
        if (md_takes) m_busy[md_adr] = 1'b0;
        if (iss_valid && iss_long && !haz) m_busy[iss_rd] = 1'b1;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 1'b0; alu_wb_adr = '0; alu_wb_data = '0;
        md_valid = 1'b0; md_adr = '0; md_data = '0;
        iss_valid = 1'b0; iss_long = 1'b0;
        iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (is_wb !== 1'b0 || wb_hold !== 1'b0 || wr_adr !== 4'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state is_wb=%b wb_hold=%b wr_adr=%0d wr_data=%0d required 0 0 0 0",
                     is_wb, wb_hold, wr_adr, wr_data);
        end
        reset = 1'b0;
        #1;
        // Build traffic: long op to r5 plus an ALU write
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 4'd5;
        alu_wb_valid = 1'b1; alu_wb_adr = 4'd1; alu_wb_data = 32'h11;
        tick();
        iss_long = 1'b0; iss_rd = 4'd0; iss_rs1 = 4'd5;
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (is_wb !== 1'b1 || hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_setup is_wb=%b hazard=%b required 1 1", is_wb, hazard);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (is_wb !== 1'b0 || hazard !== 1'b0 || wb_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async is_wb=%b hazard=%b wb_hold=%b required 0 0 0",
                     is_wb, hazard, wb_hold);
        end
        idle_inputs();
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_only();
        alu_wb_valid = 1'b1; alu_wb_adr = 4'd3; alu_wb_data = 32'd30;
        tick();
        checks++;
        if (is_wb !== 1'b1 || wr_adr !== 4'd3 || wr_data !== 32'd30) begin
            errors++;
            $display("[TB] FAIL alu_write is_wb=%b wr_adr=%0d wr_data=%0d required 1 3 30",
                     is_wb, wr_adr, wr_data);
        end
        alu_wb_valid = 1'b0;
        tick();
        checks++;
        if (is_wb !== 1'b0 || wr_adr !== 4'd3) begin
            errors++;
            $display("[TB] FAIL alu_idle is_wb=%b wr_adr=%0d required 0 3", is_wb, wr_adr);
        end
    endtask

    task automatic test_collision();
        alu_wb_valid = 1'b1; alu_wb_adr = 4'd2; alu_wb_data = 32'd20;
        md_valid = 1'b1; md_adr = 4'd7; md_data = 32'd70;
        #1;
        checks++;
        if (md_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collide_ready got %b required 0", md_ready);
        end
        tick();
        checks++;
        if (is_wb !== 1'b1 || wr_adr !== 4'd2 || wr_data !== 32'd20) begin
            errors++;
            $display("[TB] FAIL collide_alu is_wb=%b wr_adr=%0d wr_data=%0d required 1 2 20",
                     is_wb, wr_adr, wr_data);
        end
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_md_ready got %b required 1", md_ready);
        end
        tick();
        checks++;
        if (is_wb !== 1'b1 || wr_adr !== 4'd7 || wr_data !== 32'd70) begin
            errors++;
            $display("[TB] FAIL collide_md is_wb=%b wr_adr=%0d wr_data=%0d required 1 7 70",
                     is_wb, wr_adr, wr_data);
        end
        md_valid = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        md_valid = 1'b1; md_adr = 4'd9; md_data = 32'd99;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            alu_wb_valid = 1'b1; alu_wb_adr = 4'(k + 1); alu_wb_data = 32'(100 + k);
            #1;
            checks++;
            if (wb_hold !== 1'b0 || md_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL starve_wait%0d wb_hold=%b md_ready=%b required 0 0",
                         k, wb_hold, md_ready);
            end
            tick();
        end
        checks++;
        if (wb_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL starve_hold got %b required 1", wb_hold);
        end
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL starve_md_ready got %b required 1", md_ready);
        end
        tick();
        checks++;
        if (is_wb !== 1'b1 || wr_adr !== 4'd9 || wr_data !== 32'd99 || wb_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL starve_steal is_wb=%b wr_adr=%0d wr_data=%0d wb_hold=%b required 1 9 99 0",
                     is_wb, wr_adr, wr_data, wb_hold);
        end
        md_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 4'd4; iss_rs1 = 4'd0; iss_rs2 = 4'd0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sb_issue hazard=%b required 0", hazard);
        end
        tick();
        iss_long = 1'b0; iss_rd = 4'd1; iss_rs1 = 4'd4; iss_rs2 = 4'd2;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_raw hazard=%b required 1", hazard);
        end
        tick();
        iss_long = 1'b1; iss_rd = 4'd4; iss_rs1 = 4'd1; iss_rs2 = 4'd2;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_waw hazard=%b required 1", hazard);
        end
        tick();
        iss_long = 1'b0; iss_rd = 4'd1; iss_rs1 = 4'd4; iss_rs2 = 4'd2;
        md_valid = 1'b1; md_adr = 4'd4; md_data = 32'h44;
        #1;
        checks++;
        if (hazard !== 1'b1 || md_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_clear_cycle hazard=%b md_ready=%b required 1 1", hazard, md_ready);
        end
        tick();
        md_valid = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sb_released hazard=%b required 0", hazard);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_set_clear();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 4'd6; iss_rs1 = 4'd0; iss_rs2 = 4'd0;
        md_valid = 1'b1; md_adr = 4'd6; md_data = 32'd66;
        #1;
        checks++;
        if (hazard !== 1'b0 || md_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL setclr_cycle hazard=%b md_ready=%b required 0 1", hazard, md_ready);
        end
        tick();
        md_valid = 1'b0;
        iss_long = 1'b0; iss_rd = 4'd0; iss_rs1 = 4'd6;
        #1;
        checks++;
        if (hazard !== 1'b1 || wr_adr !== 4'd6) begin
            errors++;
            $display("[TB] FAIL setclr_busy hazard=%b wr_adr=%0d required 1 6", hazard, wr_adr);
        end
        iss_valid = 1'b0;
        md_valid = 1'b1; md_adr = 4'd6; md_data = 32'd67;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit prev_hold;
        prev_hold = wb_hold;
        for (int n = 0; n < 400; n++) begin
            alu_wb_valid = ($urandom_range(0, 9) < 6);
            alu_wb_adr   = 4'($urandom);
            alu_wb_data  = $urandom;
            md_valid     = ($urandom_range(0, 9) < 5);
            md_adr       = 4'($urandom);
            md_data      = $urandom;
            iss_valid    = ($urandom_range(0, 9) < 7);
            iss_long     = ($urandom_range(0, 9) < 3);
            iss_rd       = 4'($urandom);
            iss_rs1      = 4'($urandom);
            iss_rs2      = 4'($urandom);
            #1;
            checks++;
            if (md_ready !== exp_md_ready() || hazard !== exp_hazard()) begin
                errors++;
                $display("[TB] FAIL rand_comb n=%0d md_ready=%b hazard=%b required %b %b",
                         n, md_ready, hazard, exp_md_ready(), exp_hazard());
            end
            tick();
            checks++;
            if (is_wb !== m_is_wb || wr_adr !== m_adr || wr_data !== m_data || wb_hold !== m_hold) begin
                errors++;
                $display("[TB] FAIL rand_regs n=%0d is_wb=%b wr_adr=%0d wr_data=%h wb_hold=%b required %b %0d %h %b",
                         n, is_wb, wr_adr, wr_data, wb_hold, m_is_wb, m_adr, m_data, m_hold);
            end
            checks++;
            if (prev_hold && wb_hold) begin
                errors++;
                $display("[TB] FAIL hold_twice n=%0d wb_hold=%b required 0", n, wb_hold);
            end
            prev_hold = wb_hold;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_collision();
        test_starvation();
        test_scoreboard();
        test_set_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
